fast2cdpaxi: RTL and testbench



---
 rtl/fast_pkg.sv | 28 ++
 rtl/fast2cdpaxi_sync_fifo_fwft.sv | 61 ++++++
 rtl/fast2cdpaxi.sv | 197 +++++++++++++++++++
 tb/tb_fast2cdpaxi.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/fast_pkg.sv
// Shared definitions for the FAST <-> AXI4-Stream converters.
// FAST beat layout: [133:132] beat type, [131:128] invalid low bytes on the
// tail beat, [127:0] payload.
package fast_pkg;

  localparam int unsigned FAST_W   = 134;
  localparam int unsigned AXI_DW   = 128;
  localparam int unsigned TYPE_MSB = 133;
  localparam int unsigned INV_LSB  = 128;

  localparam logic [1:0] FAST_HEAD = 2'b01;
  localparam logic [1:0] FAST_BODY = 2'b11;
  localparam logic [1:0] FAST_TAIL = 2'b10;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_SEND,
    RD_DROP
  } rd_state_e;

  // Byte enables for a tail beat whose lowest 'inv' bytes carry no data.
  function automatic logic [AXI_DW/8-1:0] tail_keep(input logic [3:0] inv);
    logic [AXI_DW/8-1:0] k;
    k = '1;
    return k << inv;
  endfunction

endpackage

// File: rtl/fast2cdpaxi_sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO.
//   wr_en_i/wr_data_i : push (ignored while full)
//   rd_en_i           : pop  (ignored while empty)
//   rd_data_o         : head entry, valid whenever empty_o is 0
//   count_o           : occupancy, 0 .. 2^AW
//   full_o / empty_o  : occupancy flags
module sync_fifo_fwft #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic [AW:0]      count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             wr_fire, rd_fire;

  assign full_o    = cnt_q[AW];
  assign empty_o   = (cnt_q == '0);
  assign count_o   = cnt_q;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign wr_fire   = wr_en_i & ~full_o;
  assign rd_fire   = rd_en_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_fire ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rd_fire ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d    = cnt_q;
    if (wr_fire && !rd_fire) cnt_d = cnt_q + 1'b1;
    if (!wr_fire && rd_fire) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/fast2cdpaxi.sv
// FAST (134-bit) to AXI4-Stream (128-bit) transmit converter, store-and-forward.
//   aclk/areset        : clock, asynchronous active-high reset
//   um2cdp_data_wr/_data    : FAST beat strobe and beat
//   um2cdp_valid_wr/_valid  : per-packet forward/discard flag, with the tail
//   um2cdp_tx_enable   : room for one maximum-size packet
//   m_axi_*            : AXI4-Stream master
//   err_pulse          : one-cycle pulse on protocol or overflow events
module fast2cdpaxi
  import fast_pkg::*;
#(
  parameter int unsigned DFIFO_AW      = 8,
  parameter int unsigned SFIFO_AW      = 7,
  parameter int unsigned MAX_PKT_BEATS = 96
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              um2cdp_data_wr,
  input  logic [FAST_W-1:0] um2cdp_data,
  input  logic              um2cdp_valid_wr,
  input  logic              um2cdp_valid,
  output logic              um2cdp_tx_enable,
  output logic              m_axi_tvalid,
  output logic [AXI_DW-1:0] m_axi_tdata,
  output logic [15:0]       m_axi_tkeep,
  output logic              m_axi_tlast,
  input  logic              m_axi_tready,
  output logic              err_pulse
);

  localparam int unsigned         DDEPTH   = 1 << DFIFO_AW;
  localparam logic [DFIFO_AW:0]   DEPTH_M1 = (DFIFO_AW+1)'(DDEPTH - 1);
  localparam logic [DFIFO_AW:0]   TXEN_LVL = (DFIFO_AW+1)'(DDEPTH - MAX_PKT_BEATS);

  // FIFO interfaces
  logic              dwr, dpop, dfull, dempty;
  logic [FAST_W-1:0] dq;
  logic [DFIFO_AW:0] dcnt;
  logic              swr, swr_data, spop, sfull, sempty;
  logic [0:0]        sq;
  logic [SFIFO_AW:0] scnt;
  logic              sfifo_unused;

  sync_fifo_fwft #(.WIDTH(FAST_W), .AW(DFIFO_AW)) u_dfifo (
    .clk(aclk), .rst(areset), .wr_en_i(dwr), .wr_data_i(um2cdp_data),
    .rd_en_i(dpop), .rd_data_o(dq), .count_o(dcnt), .full_o(dfull), .empty_o(dempty)
  );

  sync_fifo_fwft #(.WIDTH(1), .AW(SFIFO_AW)) u_sfifo (
    .clk(aclk), .rst(areset), .wr_en_i(swr), .wr_data_i(swr_data),
    .rd_en_i(spop), .rd_data_o(sq), .count_o(scnt), .full_o(sfull), .empty_o(sempty)
  );

  assign sfifo_unused = ^scnt;

  // ---------------- write side ----------------
  logic       in_pkt_q, in_pkt_d, bad_q, bad_d, err_q, err_d, txen_q;
  logic [1:0] wtype;

  assign wtype = um2cdp_data[TYPE_MSB -: 2];

  always_comb begin
    in_pkt_d = in_pkt_q;
    bad_d    = bad_q;
    dwr      = 1'b0;
    swr      = 1'b0;
    swr_data = 1'b0;
    err_d    = 1'b0;
    if (um2cdp_data_wr) begin
      case (wtype)
        // A head also needs room for its tail, so it is refused at depth-1
        // like a middle beat; this keeps every stored packet tail-terminated.
        FAST_HEAD: begin
          if (in_pkt_q || dcnt >= DEPTH_M1) err_d = 1'b1;
          else begin
            dwr      = 1'b1;
            in_pkt_d = 1'b1;
            bad_d    = 1'b0;
          end
        end
        FAST_BODY: begin
          if (!in_pkt_q) err_d = 1'b1;
          else if (dcnt < DEPTH_M1) dwr = 1'b1;
          else begin
            bad_d = 1'b1;
            err_d = 1'b1;
          end
        end
        FAST_TAIL: begin
          if (!in_pkt_q) err_d = 1'b1;
          else begin
            dwr      = 1'b1;
            swr      = 1'b1;
            swr_data = um2cdp_valid & ~bad_q & um2cdp_valid_wr;
            in_pkt_d = 1'b0;
            if (!um2cdp_valid_wr || dfull || sfull) err_d = 1'b1;
          end
        end
        default: err_d = 1'b1;
      endcase
    end
    if (um2cdp_valid_wr && !(um2cdp_data_wr && wtype == FAST_TAIL)) err_d = 1'b1;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      in_pkt_q <= 1'b0;
      bad_q    <= 1'b0;
      err_q    <= 1'b0;
      txen_q   <= 1'b0;
    end else begin
      in_pkt_q <= in_pkt_d;
      bad_q    <= bad_d;
      err_q    <= err_d;
      txen_q   <= (dcnt <= TXEN_LVL);
    end
  end

  assign um2cdp_tx_enable = txen_q;
  assign err_pulse        = err_q;

  // ---------------- read side ----------------
  rd_state_e         state_q, state_d;
  logic              tvalid_q, tvalid_d, tlast_q, tlast_d;
  logic [AXI_DW-1:0] tdata_q, tdata_d;
  logic [15:0]       tkeep_q, tkeep_d;
  logic              rtail;

  assign rtail = (dq[TYPE_MSB -: 2] == FAST_TAIL);

  always_comb begin
    state_d  = state_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    tdata_d  = tdata_q;
    tkeep_d  = tkeep_q;
    dpop     = 1'b0;
    spop     = 1'b0;
    case (state_q)
      RD_IDLE: begin
        if (!sempty) begin
          spop    = 1'b1;
          state_d = sq[0] ? RD_SEND : RD_DROP;
        end
      end
      RD_SEND: begin
        // Once the tail sits in the output register, nothing more is loaded
        // until it is accepted: the next beat belongs to another packet.
        if (tvalid_q && tlast_q) begin
          if (m_axi_tready) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            state_d  = RD_IDLE;
          end
        end else if (!tvalid_q || m_axi_tready) begin
          if (!dempty) begin
            dpop     = 1'b1;
            tvalid_d = 1'b1;
            tdata_d  = dq[AXI_DW-1:0];
            tlast_d  = rtail;
            tkeep_d  = rtail ? tail_keep(dq[INV_LSB +: 4]) : '1;
          end else begin
            tvalid_d = 1'b0;
          end
        end
      end
      RD_DROP: begin
        if (!dempty) begin
          dpop = 1'b1;
          if (rtail) state_d = RD_IDLE;
        end
      end
      default: state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q  <= RD_IDLE;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tdata_q  <= '0;
      tkeep_q  <= '0;
    end else begin
      state_q  <= state_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      tdata_q  <= tdata_d;
      tkeep_q  <= tkeep_d;
    end
  end

  assign m_axi_tvalid = tvalid_q;
  assign m_axi_tdata  = tdata_q;
  assign m_axi_tkeep  = tkeep_q;
  assign m_axi_tlast  = tlast_q;

endmodule

// File: tb/tb_fast2cdpaxi.sv
module tb_fast2cdpaxi;

  localparam logic [1:0] HD = 2'b01;
  localparam logic [1:0] BD = 2'b11;
  localparam logic [1:0] TL = 2'b10;

  logic         aclk = 1'b0;
  logic         areset;
  logic         um2cdp_data_wr, um2cdp_valid_wr, um2cdp_valid;
  logic [133:0] um2cdp_data;
  logic         um2cdp_tx_enable;
  logic         m_axi_tvalid, m_axi_tlast, m_axi_tready, err_pulse;
  logic [127:0] m_axi_tdata;
  logic [15:0]  m_axi_tkeep;

  fast2cdpaxi #(.DFIFO_AW(8), .SFIFO_AW(7), .MAX_PKT_BEATS(96)) dut (
    .aclk(aclk), .areset(areset),
    .um2cdp_data_wr(um2cdp_data_wr), .um2cdp_data(um2cdp_data),
    .um2cdp_valid_wr(um2cdp_valid_wr), .um2cdp_valid(um2cdp_valid),
    .um2cdp_tx_enable(um2cdp_tx_enable),
    .m_axi_tvalid(m_axi_tvalid), .m_axi_tdata(m_axi_tdata), .m_axi_tkeep(m_axi_tkeep),
    .m_axi_tlast(m_axi_tlast), .m_axi_tready(m_axi_tready), .err_pulse(err_pulse)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [127:0] d;
    logic [15:0]  k;
    logic         l;
  } beat_t;

  int    vectors = 0;
  int    miscompares = 0;
  int    errs = 0;
  beat_t q[$];
  logic  prev_stall = 1'b0;
  beat_t prev_b;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] pl(input int unsigned pid, input int unsigned i);
    return {32'hCAFE_0000, 32'(pid), 32'h0, 32'(i)};
  endfunction

  // Monitor: handshakes seen at negedge complete on the following posedge.
  always @(negedge aclk) begin
    if (areset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_tvalid", 160'(m_axi_tvalid), 160'(1));
        chk("stall_beat", 160'({m_axi_tdata, m_axi_tkeep, m_axi_tlast}), 160'(prev_b));
      end
      if (err_pulse) errs++;
      if (m_axi_tvalid && m_axi_tready) q.push_back({m_axi_tdata, m_axi_tkeep, m_axi_tlast});
      prev_stall = m_axi_tvalid && !m_axi_tready;
      prev_b     = {m_axi_tdata, m_axi_tkeep, m_axi_tlast};
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic beat(input logic [1:0] t, input logic [3:0] inv, input logic [127:0] p,
                      input logic vwr, input logic v);
    um2cdp_data_wr  = 1'b1;
    um2cdp_data     = {t, inv, p};
    um2cdp_valid_wr = vwr;
    um2cdp_valid    = v;
    tick();
    um2cdp_data_wr  = 1'b0;
    um2cdp_valid_wr = 1'b0;
    um2cdp_valid    = 1'b0;
  endtask

  task automatic pkt(input int unsigned pid, input int unsigned n, input logic [3:0] inv,
                     input logic v);
    for (int unsigned i = 0; i < n; i++) begin
      if (i == 0)          beat(HD, 4'd0, pl(pid, i), 1'b0, 1'b0);
      else if (i == n - 1) beat(TL, inv, pl(pid, i), 1'b1, v);
      else                 beat(BD, 4'd0, pl(pid, i), 1'b0, 1'b0);
    end
  endtask

  task automatic wait_beats(input string tag, input int n);
    int c = 0;
    while (q.size() < n && c < 200) begin
      tick();
      c++;
    end
    repeat (4) tick();
    chk(tag, 160'(q.size()), 160'(n));
  endtask

  task automatic expect_beat(input string tag, input int unsigned pid, input int unsigned i,
                             input logic [15:0] k, input logic l);
    beat_t b;
    b = '0;
    if (q.size() > 0) b = q.pop_front();
    chk(tag, 160'(b), 160'({pl(pid, i), k, l}));
  endtask

  initial begin
    int e0;
    int c;
    logic [3:0] pat;
    areset = 1'b0;
    um2cdp_data_wr = 1'b0; um2cdp_data = '0;
    um2cdp_valid_wr = 1'b0; um2cdp_valid = 1'b0;
    m_axi_tready = 1'b0;
    #2 areset = 1'b1;
    #2;
    chk("rst_tvalid", 160'(m_axi_tvalid), 160'(0));
    chk("rst_tdata", 160'(m_axi_tdata), 160'(0));
    chk("rst_tkeep_tlast", 160'({m_axi_tkeep, m_axi_tlast}), 160'(0));
    chk("rst_err", 160'(err_pulse), 160'(0));
    chk("rst_txen", 160'(um2cdp_tx_enable), 160'(0));
    tick(); tick();
    areset = 1'b0;
    tick();
    chk("txen_after_rst", 160'(um2cdp_tx_enable), 160'(1));

    // 4-beat valid packet, tready held high
    m_axi_tready = 1'b1;
    e0 = errs;
    pkt(1, 4, 4'd3, 1'b1);
    c = 0;
    while (!m_axi_tvalid && c < 10) begin
      tick();
      c++;
    end
    chk("p1_latency", 160'(c <= 3 && m_axi_tvalid), 160'(1));
    wait_beats("p1_count", 4);
    expect_beat("p1_b0", 1, 0, 16'hFFFF, 1'b0);
    expect_beat("p1_b1", 1, 1, 16'hFFFF, 1'b0);
    expect_beat("p1_b2", 1, 2, 16'hFFFF, 1'b0);
    expect_beat("p1_b3", 1, 3, 16'hFFF8, 1'b1);
    chk("p1_err", 160'(errs - e0), 160'(0));

    // discarded packet followed by a 2-beat valid one
    e0 = errs;
    pkt(2, 4, 4'd0, 1'b0);
    pkt(3, 2, 4'd0, 1'b1);
    wait_beats("p3_count", 2);
    expect_beat("p3_b0", 3, 0, 16'hFFFF, 1'b0);
    expect_beat("p3_b1", 3, 1, 16'hFFFF, 1'b1);
    chk("p3_err", 160'(errs - e0), 160'(0));

    // 6-beat packet with tready pattern 1,0,0,1
    m_axi_tready = 1'b0;
    pkt(4, 6, 4'd5, 1'b1);
    c = 0;
    while (!m_axi_tvalid && c < 10) begin
      tick();
      c++;
    end
    pat = 4'b1001;
    c = 0;
    while (q.size() < 6 && c < 60) begin
      m_axi_tready = pat[c % 4];
      tick();
      c++;
    end
    m_axi_tready = 1'b1;
    wait_beats("p4_count", 6);
    for (int unsigned i = 0; i < 6; i++)
      expect_beat($sformatf("p4_b%0d", i), 4, i, (i == 5) ? 16'hFFE0 : 16'hFFFF, i == 5);

    // 300-beat overflow packet with tready low
    m_axi_tready = 1'b0;
    e0 = errs;
    chk("ovf_txen_start", 160'(um2cdp_tx_enable), 160'(1));
    beat(HD, 4'd0, pl(5, 0), 1'b0, 1'b0);
    for (int unsigned i = 1; i <= 298; i++) begin
      beat(BD, 4'd0, pl(5, i), 1'b0, 1'b0);
      if (i == 199) chk("ovf_txen_low", 160'(um2cdp_tx_enable), 160'(0));
    end
    beat(TL, 4'd0, pl(5, 299), 1'b1, 1'b1);
    m_axi_tready = 1'b1;
    c = 0;
    while (!um2cdp_tx_enable && c < 400) begin
      tick();
      c++;
    end
    chk("ovf_txen_back", 160'(um2cdp_tx_enable), 160'(1));
    repeat (4) tick();
    chk("ovf_err", 160'(errs - e0), 160'(44));
    chk("ovf_no_beats", 160'(q.size()), 160'(0));

    // orphan middle, head, duplicate head, tail
    e0 = errs;
    beat(BD, 4'd0, pl(6, 9), 1'b0, 1'b0);
    beat(HD, 4'd0, pl(6, 0), 1'b0, 1'b0);
    beat(HD, 4'd0, pl(6, 1), 1'b0, 1'b0);
    beat(TL, 4'd0, pl(6, 2), 1'b1, 1'b1);
    wait_beats("p6_count", 2);
    expect_beat("p6_b0", 6, 0, 16'hFFFF, 1'b0);
    expect_beat("p6_b1", 6, 2, 16'hFFFF, 1'b1);
    chk("p6_err", 160'(errs - e0), 160'(2));

    // reset in the middle of sending a 5-beat packet
    pkt(7, 5, 4'd0, 1'b1);
    c = 0;
    while (q.size() < 2 && c < 20) begin
      tick();
      c++;
    end
    areset = 1'b1;
    #1;
    chk("midrst_tvalid", 160'(m_axi_tvalid), 160'(0));
    chk("midrst_tlast", 160'(m_axi_tlast), 160'(0));
    chk("midrst_txen", 160'(um2cdp_tx_enable), 160'(0));
    tick(); tick();
    areset = 1'b0;
    tick();
    chk("midrst_txen_back", 160'(um2cdp_tx_enable), 160'(1));
    chk("p7_count", 160'(q.size()), 160'(2));
    expect_beat("p7_b0", 7, 0, 16'hFFFF, 1'b0);
    expect_beat("p7_b1", 7, 1, 16'hFFFF, 1'b0);
    pkt(8, 3, 4'd2, 1'b1);
    wait_beats("p8_count", 3);
    expect_beat("p8_b0", 8, 0, 16'hFFFF, 1'b0);
    expect_beat("p8_b1", 8, 1, 16'hFFFF, 1'b0);
    expect_beat("p8_b2", 8, 2, 16'hFFFC, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
